spi_master_param: RTL and testbench

Parametrised SPI master, the successor to the 8-bit fixed-mode serial shifter. It adds generic word width, multiple chip selects, all four SPI modes, selectable bit order, chip-select setup/hold framing and a one-cycle completion strobe. It sits between a byte or word command engine and off-chip SPI peripherals, and one instance drives all peripherals sharing SCLK/DO/DI.

---
 rtl/spi_master_param.sv | 147 ++++++++++++++
 tb/tb_spi_master_param.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_param.sv
// Parametrised SPI master: generic word width, NCS chip selects, all four SPI modes,
// selectable bit order, chip-select setup/hold framing and a one-cycle done strobe.
module spi_master_param #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 8,
    parameter int NCS   = 1,
    parameter int CSW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] divisor,
    input  logic             cpol,
    input  logic             cpha,
    input  logic             lsb_first,
    input  logic [CSW-1:0]   cs_sel,
    input  logic [WIDTH-1:0] din,
    input  logic             start,
    output logic [WIDTH-1:0] dout,
    output logic             busy,
    output logic             done,
    output logic             SCLK,
    output logic             DO,
    input  logic             DI,
    output logic [NCS-1:0]   CS_n
);

    localparam int EW = $clog2(2 * WIDTH + 1);

    typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

    state_t           state, state_nx;
    logic [DIV_W-1:0] div_q, cnt;
    logic             cpol_q, cpha_q, lsb_q;
    logic [WIDTH-1:0] tx, rx;
    logic [EW-1:0]    edge_cnt;
    logic [NCS-1:0]   cs_dec;
    logic             phase_end, last_edge, odd_edge, sample, drive;

    assign phase_end = (cnt == div_q);
    assign last_edge = (edge_cnt == EW'(2 * WIDTH - 1));
    // edge_cnt holds the number of edges already produced, so edge number = edge_cnt + 1
    assign odd_edge  = ~edge_cnt[0];
    assign sample    = phase_end && (odd_edge != cpha_q);
    assign drive     = phase_end && !sample && !(!cpha_q && last_edge);

    // Out-of-range selects decode to no active line
    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < NCS; i++)
            if (32'(cs_sel) == i) cs_dec[i] = 1'b0;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = LEAD;
            LEAD:    if (phase_end) state_nx = XFER;
            XFER:    if (phase_end && last_edge) state_nx = TRAIL;
            TRAIL:   if (phase_end) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q    <= '0;
            cnt      <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            tx       <= '0;
            rx       <= '0;
            edge_cnt <= '0;
            dout     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            SCLK     <= 1'b0;
            DO       <= 1'b0;
            CS_n     <= '1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    SCLK     <= cpol;
                    DO       <= 1'b0;
                    CS_n     <= '1;
                    cnt      <= '0;
                    edge_cnt <= '0;
                    if (start) begin
                        div_q  <= divisor;
                        cpol_q <= cpol;
                        cpha_q <= cpha;
                        lsb_q  <= lsb_first;
                        busy   <= 1'b1;
                        rx     <= '0;
                        CS_n   <= cs_dec;
                        if (!cpha) begin
                            DO <= lsb_first ? din[0] : din[WIDTH-1];
                            tx <= lsb_first ? (din >> 1) : (din << 1);
                        end else begin
                            tx <= din;
                        end
                    end
                end
                LEAD: begin
                    SCLK <= cpol_q;
                    cnt  <= phase_end ? '0 : cnt + 1'b1;
                end
                XFER: begin
                    if (phase_end) begin
                        cnt      <= '0;
                        SCLK     <= ~SCLK;
                        edge_cnt <= edge_cnt + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    // Received bits enter from the side that keeps natural bit weight
                    if (sample)
                        rx <= lsb_q ? {DI, rx[WIDTH-1:1]} : {rx[WIDTH-2:0], DI};
                    if (drive) begin
                        DO <= lsb_q ? tx[0] : tx[WIDTH-1];
                        tx <= lsb_q ? (tx >> 1) : (tx << 1);
                    end
                end
                TRAIL: begin
                    if (phase_end) begin
                        cnt  <= '0;
                        CS_n <= '1;
                        DO   <= 1'b0;
                        dout <= rx;
                        done <= 1'b1;
                        busy <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_param.sv
// Self-checking bench for spi_master_param: table of transfers against an SPI slave model,
// a dout scoreboard per instance, plus abort/re-arm sequences.
module tb_spi_master_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 8-bit, 4 chip-select instance
    logic [7:0] div8 = '0, din8 = '0, dout8;
    logic       cpol8 = 0, cpha8 = 0, lsb8 = 0, start8 = 0;
    logic [2:0] sel8 = '0;
    logic       busy8, done8, sclk8, do8, di8;
    logic [3:0] cs_n8;

    // 16-bit, single chip-select instance (loopback)
    logic [3:0]  div16 = '0;
    logic [15:0] din16 = '0, dout16;
    logic        cpol16 = 0, cpha16 = 0, lsb16 = 0, start16 = 0;
    logic [0:0]  sel16 = '0;
    logic        busy16, done16, sclk16, do16;
    logic [0:0]  cs_n16;

    spi_master_param #(.WIDTH(8), .DIV_W(8), .NCS(4), .CSW(3)) dut8 (
        .clk(clk), .rst(rst), .divisor(div8), .cpol(cpol8), .cpha(cpha8),
        .lsb_first(lsb8), .cs_sel(sel8), .din(din8), .start(start8),
        .dout(dout8), .busy(busy8), .done(done8), .SCLK(sclk8), .DO(do8),
        .DI(di8), .CS_n(cs_n8));

    spi_master_param #(.WIDTH(16), .DIV_W(4), .NCS(1), .CSW(1)) dut16 (
        .clk(clk), .rst(rst), .divisor(div16), .cpol(cpol16), .cpha(cpha16),
        .lsb_first(lsb16), .cs_sel(sel16), .din(din16), .start(start16),
        .dout(dout16), .busy(busy16), .done(done16), .SCLK(sclk16), .DO(do16),
        .DI(do16), .CS_n(cs_n16));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave model: selected while any CS_n line is low; mode follows the bench's inputs
    logic       loop8 = 1'b1;
    logic [7:0] slv_tx = '0, slv_rx = '0;
    int         slv_idx = 0;
    logic       slv_di = 1'b0;
    logic       cs_any;
    assign cs_any = ~&cs_n8;
    assign di8    = loop8 ? do8 : slv_di;

    function automatic logic slv_bit(input int i);
        logic [7:0] t;
        if (i > 7) return 1'b0;
        t = lsb8 ? (slv_tx >> i) : (slv_tx << i);
        return lsb8 ? t[0] : t[7];
    endfunction

    always @(posedge cs_any) begin
        slv_idx = 0;
        slv_rx  = '0;
        if (!cpha8) slv_di = slv_bit(0);
    end

    always @(sclk8) begin
        if (cs_any) begin
            if ((sclk8 != cpol8) != cpha8) begin
                slv_rx = lsb8 ? {do8, slv_rx[7:1]} : {slv_rx[6:0], do8};
            end else if (cpha8) begin
                slv_di = slv_bit(slv_idx);
                slv_idx++;
            end else begin
                slv_idx++;
                slv_di = slv_bit(slv_idx);
            end
        end
    end

    // Scoreboards: expected dout pushed at start, popped on done
    logic [7:0]  q8[$];
    logic [15:0] q16[$];

    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) chk("dout8_unexpected_done", 32'(dout8), 32'hFFFF_FFFF);
            else                chk("dout8", 32'(dout8), 32'(q8.pop_front()));
            chk("busy8_at_done", 32'(busy8), 32'd0);
        end
        if (done16) begin
            if (q16.size() == 0) chk("dout16_unexpected_done", 32'(dout16), 32'hFFFF_FFFF);
            else                 chk("dout16", 32'(dout16), 32'(q16.pop_front()));
            chk("busy16_at_done", 32'(busy16), 32'd0);
        end
    end

    typedef struct {
        logic       cpol, cpha, lsb;
        logic [7:0] div;
        logic [2:0] sel;
        logic [7:0] din;
        logic       loop;
        logic [7:0] slv;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic run8(input vec_t v, input bit mid_start);
        int lat, edges, cs_low, hp_min, hp_max, since, d, busy_cnt;
        logic prev_sclk, first_do;
        logic [3:0] cs_and, exp_cs;
        d = int'(v.div) + 1;
        @(negedge clk);
        cpol8 = v.cpol; cpha8 = v.cpha; lsb8 = v.lsb; div8 = v.div;
        sel8 = v.sel; din8 = v.din; loop8 = v.loop; slv_tx = v.slv;
        @(negedge clk);
        chk("idle_sclk", 32'(sclk8), 32'(v.cpol));
        start8 = 1'b1;
        q8.push_back(v.exp);
        lat = 0; edges = 0; cs_low = 0; cs_and = '1; hp_min = 100000; hp_max = 0;
        since = 0; prev_sclk = sclk8; first_do = 1'b0;
        @(negedge clk);
        lat = 1;
        start8 = 1'b0;
        while (!done8 && lat < 3000) begin
            if (sclk8 !== prev_sclk) begin
                edges++;
                if (edges > 1) begin
                    if (since < hp_min) hp_min = since;
                    if (since > hp_max) hp_max = since;
                end
                if (edges == 1) first_do = do8;
                since = 0;
                prev_sclk = sclk8;
            end
            if (cs_n8 != 4'hF) cs_low++;
            cs_and &= cs_n8;
            start8 = mid_start && edges == 3 && since == 0;
            since++;
            @(negedge clk);
            lat++;
        end
        start8 = 1'b0;
        exp_cs = (v.sel < 4) ? ~(4'b0001 << v.sel) : 4'hF;
        chk("latency", 32'(lat), 32'((2 * 8 + 2) * d + 1));
        chk("sclk_edges", 32'(edges), 32'd16);
        chk("half_period_min", 32'(hp_min), 32'(d));
        chk("half_period_max", 32'(hp_max), 32'(d));
        chk("cs_lines", 32'(cs_and), 32'(exp_cs));
        chk("cs_low_cycles", 32'(cs_low), (v.sel < 4) ? 32'((2 * 8 + 2) * d) : 32'd0);
        chk("first_do", 32'(first_do), 32'(v.lsb ? v.din[0] : v.din[7]));
        chk("sclk_after", 32'(sclk8), 32'(v.cpol));
        chk("cs_after", 32'(cs_n8), 32'hF);
        if (!v.loop) chk("slave_rx", 32'(slv_rx), 32'(v.din));
        if (mid_start) begin
            busy_cnt = 0;
            repeat (8) begin
                @(negedge clk);
                if (busy8) busy_cnt++;
            end
            chk("ignored_start", 32'(busy_cnt), 32'd0);
        end
    endtask

    initial begin
        int edges, n, done_cnt, lat;
        logic prev_sclk;

        vecs[0] = '{cpol:0, cpha:0, lsb:0, div:8'd0, sel:3'd0, din:8'hA5, loop:1, slv:8'h00, exp:8'hA5};
        vecs[1] = '{cpol:1, cpha:1, lsb:0, div:8'd3, sel:3'd0, din:8'hF0, loop:0, slv:8'h3C, exp:8'h3C};
        vecs[2] = '{cpol:0, cpha:1, lsb:1, div:8'd0, sel:3'd0, din:8'h01, loop:0, slv:8'h81, exp:8'h81};
        vecs[3] = '{cpol:0, cpha:0, lsb:0, div:8'd1, sel:3'd2, din:8'h3C, loop:1, slv:8'h00, exp:8'h3C};
        vecs[4] = '{cpol:0, cpha:0, lsb:0, div:8'd0, sel:3'd5, din:8'h5A, loop:1, slv:8'h00, exp:8'h5A};
        vecs[5] = '{cpol:1, cpha:0, lsb:0, div:8'd2, sel:3'd1, din:8'h96, loop:0, slv:8'hC3, exp:8'hC3};
        vecs[6] = '{cpol:0, cpha:1, lsb:0, div:8'd0, sel:3'd3, din:8'h6B, loop:0, slv:8'hD4, exp:8'hD4};

        repeat (3) @(negedge clk);
        chk("rst_sclk", 32'(sclk8), 32'd0);
        chk("rst_do", 32'(do8), 32'd0);
        chk("rst_cs", 32'(cs_n8), 32'hF);
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_dout", 32'(dout8), 32'd0);
        chk("rst_dout16", 32'(dout16), 32'd0);
        chk("rst_sclk16", 32'(sclk16), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run8(vecs[i], i == 3);

        // Abort at edge 7 of a 0xFF transfer
        @(negedge clk);
        cpol8 = 0; cpha8 = 0; lsb8 = 0; div8 = 8'd1; sel8 = 3'd0; din8 = 8'hFF; loop8 = 1'b1;
        @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        prev_sclk = sclk8; edges = 0; n = 0;
        while (edges < 7 && n < 500) begin
            @(negedge clk);
            n++;
            if (sclk8 !== prev_sclk) begin
                edges++;
                prev_sclk = sclk8;
            end
        end
        chk("abort_edge_reached", 32'(edges), 32'd7);
        #2 rst = 1'b1;
        #1;
        chk("abort_sclk", 32'(sclk8), 32'd0);
        chk("abort_cs", 32'(cs_n8), 32'hF);
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_dout", 32'(dout8), 32'd0);
        chk("abort_do", 32'(do8), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (done8) done_cnt++;
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        run8(vecs[0], 1'b0);

        // 16-bit mode 2 loopback with start held high across two transfers
        @(negedge clk);
        cpol16 = 1; cpha16 = 0; lsb16 = 0; div16 = 4'd0; din16 = 16'hBEEF; sel16 = 1'b0;
        @(negedge clk);
        chk("w16_idle_sclk", 32'(sclk16), 32'd1);
        start16 = 1'b1;
        q16.push_back(16'hBEEF);
        q16.push_back(16'hBEEF);
        lat = 0;
        while (!done16 && lat < 500) begin
            @(negedge clk);
            lat++;
        end
        chk("w16_latency", 32'(lat), 32'd35);
        @(negedge clk);
        chk("w16_rearm_busy", 32'(busy16), 32'd1);
        start16 = 1'b0;
        lat = 1;
        while (!done16 && lat < 500) begin
            @(negedge clk);
            lat++;
        end
        chk("w16_latency2", 32'(lat), 32'd35);
        repeat (4) @(negedge clk);
        chk("w16_idle_after", 32'(busy16), 32'd0);

        chk("q8_empty", 32'(q8.size()), 32'd0);
        chk("q16_empty", 32'(q16.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
